// File: rtl/demux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// demux_sel_sequencer
//
// Purpose:
//   Clocked upstream driver for a 1xNUM_CH demultiplexer. A start pulse
//   sampled in IDLE launches a sweep of the select output s through channels
//   0..NUM_CH-1. Each channel is held for a programmable dwell, latched at
//   start, with a dwell of 0 treated as 1. One data bit per channel is taken
//   from din at each channel entry and presented on datain. strobe marks the
//   first cycle of every channel. done pulses once after the last channel,
//   and stop aborts an active sweep.
//
// Configuration macro:
//   SEQ_REPEAT_EN - when defined, the sweep wraps from channel NUM_CH-1 back
//                   to channel 0 instead of ending. done pulses on each wrap,
//                   busy stays high, and only stop or reset ends the sweep.
//
// Ports:
//   clk     in   1          system clock, rising edge
//   rst_n   in   1          asynchronous active-low reset
//   start   in   1          begin a sweep (sampled only in IDLE)
//   stop    in   1          abort the active sweep
//   dwell   in   DWELL_W    cycles per channel (latched at start, 0 -> 1)
//   din     in   1          data bit sampled at each channel entry
//   s       out  SEL_W      demux select
//   datain  out  1          demux data input
//   strobe  out  1          pulse on the first cycle of each channel
//   busy    out  1          high while a sweep is active
//   done    out  1          pulse after the last channel completes
//   ch_cnt  out  SEL_W+1    channels entered in the current or last sweep
// -----------------------------------------------------------------------------
module demux_sel_sequencer #(
  parameter int NUM_CH  = 8,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               din,
  output logic [SEL_W-1:0]   s,
  output logic               datain,
  output logic               strobe,
  output logic               busy,
  output logic               done,
  output logic [SEL_W:0]     ch_cnt
);

  localparam int CNT_W = SEL_W + 1;
  localparam logic [SEL_W-1:0]   LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0]   FIRST_CH = {SEL_W{1'b0}};
  localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);
  localparam logic [DWELL_W-1:0] ONE_DW   = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] ZERO_DW  = {DWELL_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A dwell of zero would never let a channel end; treat it as one cycle.
  function automatic logic [DWELL_W-1:0] norm_dwell(input logic [DWELL_W-1:0] d);
    return (d == ZERO_DW) ? ONE_DW : d;
  endfunction

  state_t             state_r,  state_s;
  logic [SEL_W-1:0]   s_r,      s_s;
  logic               datain_r, datain_s;
  logic               strobe_r, strobe_s;
  logic               busy_r,   busy_s;
  logic               done_r,   done_s;
  logic [CNT_W-1:0]   ch_cnt_r, ch_cnt_s;
  logic [DWELL_W-1:0] dwell_q_r, dwell_q_s;
  logic [DWELL_W-1:0] cnt_r,    cnt_s;

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_s   = state_r;
    s_s       = s_r;
    datain_s  = 1'b0;
    strobe_s  = 1'b0;
    busy_s    = busy_r;
    done_s    = 1'b0;
    ch_cnt_s  = ch_cnt_r;
    dwell_q_s = dwell_q_r;
    cnt_s     = cnt_r;

    case (state_r)
      IDLE: begin
        // start wins over a simultaneous stop; stop alone does nothing here.
        if (start) begin
          state_s   = DRIVE;
          dwell_q_s = norm_dwell(dwell);
          cnt_s     = norm_dwell(dwell) - ONE_DW;
          s_s       = FIRST_CH;
          datain_s  = din;
          strobe_s  = 1'b1;
          busy_s    = 1'b1;
          ch_cnt_s  = ONE_CNT;
        end else begin
          busy_s    = 1'b0;
        end
      end

      DRIVE: begin
        datain_s = datain_r;
        // stop outranks a channel advance; s and ch_cnt keep the abort point.
        if (stop) begin
          state_s  = IDLE;
          busy_s   = 1'b0;
          datain_s = 1'b0;
        end else if (cnt_r == ZERO_DW) begin
          if (s_r == LAST_CH) begin
`ifdef SEQ_REPEAT_EN
            s_s      = FIRST_CH;
            datain_s = din;
            strobe_s = 1'b1;
            ch_cnt_s = ONE_CNT;
            cnt_s    = dwell_q_r - ONE_DW;
            done_s   = 1'b1;
`else
            state_s  = DONE;
            busy_s   = 1'b0;
            datain_s = 1'b0;
            done_s   = 1'b1;
`endif
          end else begin
            s_s      = s_r + SEL_W'(1);
            datain_s = din;
            strobe_s = 1'b1;
            ch_cnt_s = ch_cnt_r + ONE_CNT;
            cnt_s    = dwell_q_r - ONE_DW;
          end
        end else begin
          cnt_s = cnt_r - ONE_DW;
        end
      end

      DONE: begin
        // Single-cycle done pulse; start is ignored until back in IDLE.
        state_s = IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs, with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      s_r       <= {SEL_W{1'b0}};
      datain_r  <= 1'b0;
      strobe_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ch_cnt_r  <= {CNT_W{1'b0}};
      dwell_q_r <= ZERO_DW;
      cnt_r     <= ZERO_DW;
    end else begin
      state_r   <= state_s;
      s_r       <= s_s;
      datain_r  <= datain_s;
      strobe_r  <= strobe_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      ch_cnt_r  <= ch_cnt_s;
      dwell_q_r <= dwell_q_s;
      cnt_r     <= cnt_s;
    end
  end

  assign s      = s_r;
  assign datain = datain_r;
  assign strobe = strobe_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign ch_cnt = ch_cnt_r;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demux_sel_sequencer
//
// Self-checking bench for demux_sel_sequencer. Inputs are applied on the
// falling edge; a reference model predicts the outputs after the following
// rising edge from elapsed time since start (channel = t / dwell, entry when
// t % dwell == 0). Outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_demux_sel_sequencer;

  localparam int NUM_CH  = 8;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic               din;
  logic [SEL_W-1:0]   s;
  logic               datain;
  logic               strobe;
  logic               busy;
  logic               done;
  logic [SEL_W:0]     ch_cnt;

  int total;
  int bad;

  // reference model state
  bit m_active;
  bit m_done_cyc;
  int m_t;
  int m_d;
  int m_s;
  int m_din;
  int m_stb;
  int m_busy;
  int m_done;
  int m_ch;

  demux_sel_sequencer #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dwell(dwell),
    .din(din), .s(s), .datain(datain), .strobe(strobe), .busy(busy),
    .done(done), .ch_cnt(ch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("s",      int'(s),      m_s);
    check("datain", int'(datain), m_din);
    check("strobe", int'(strobe), m_stb);
    check("busy",   int'(busy),   m_busy);
    check("done",   int'(done),   m_done);
    check("ch_cnt", int'(ch_cnt), m_ch);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_done_cyc = 1'b0; m_t = 0; m_d = 1;
    m_s = 0; m_din = 0; m_stb = 0; m_busy = 0; m_done = 0; m_ch = 0;
  endtask

  // Predict outputs after the next rising edge given the inputs now applied.
  task automatic model_step(input bit st, input bit sp, input int dw, input bit di);
    if (m_active) begin
      if (sp) begin
        m_active = 1'b0;
        m_busy = 0; m_din = 0; m_stb = 0; m_done = 0;
      end else begin
        m_t++;
`ifdef SEQ_REPEAT_EN
        m_s   = (m_t / m_d) % NUM_CH;
        m_ch  = m_s + 1;
        m_stb = (m_t % m_d == 0) ? 1 : 0;
        if (m_stb == 1) m_din = di;
        m_done = (m_stb == 1 && m_s == 0) ? 1 : 0;
`else
        if (m_t == NUM_CH * m_d) begin
          m_active = 1'b0; m_done_cyc = 1'b1;
          m_done = 1; m_busy = 0; m_din = 0; m_stb = 0;
          m_s = NUM_CH - 1; m_ch = NUM_CH;
        end else begin
          m_s   = m_t / m_d;
          m_ch  = m_s + 1;
          m_stb = (m_t % m_d == 0) ? 1 : 0;
          if (m_stb == 1) m_din = di;
        end
`endif
      end
    end else if (m_done_cyc) begin
      m_done_cyc = 1'b0;
      m_done = 0;
    end else if (st) begin
      m_active = 1'b1; m_t = 0;
      m_d = (dw == 0) ? 1 : dw;
      m_s = 0; m_din = di; m_stb = 1; m_busy = 1; m_ch = 1; m_done = 0;
    end else begin
      m_stb = 0; m_done = 0; m_din = 0; m_busy = 0;
    end
  endtask

  // One clock: check the previous edge's result, then drive the next inputs.
  task automatic cycle(input bit st, input bit sp, input int dw, input bit di);
    @(negedge clk);
    check_all();
    start = st; stop = sp; dwell = DWELL_W'(dw); din = di;
    model_step(st, sp, dw, di);
  endtask

  // Pull rst_n low between edges and confirm outputs clear without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dwell = '0; din = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 0, 1'b0);

    // dwell 10, din held high: full sweep then done
    cycle(1'b1, 1'b0, 10, 1'b1);
    for (int i = 0; i < 85; i++) cycle(1'b0, 1'b0, 10, 1'b1);
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);

    // dwell 0 acts as 1, din toggles at each entry
    cycle(1'b1, 1'b0, 0, 1'b1);
    for (int i = 1; i < 12; i++) cycle(1'b0, 1'b0, 0, (i % 2) == 0);
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);

    // dwell 10, stop at cycle 25
    cycle(1'b1, 1'b0, 10, 1'b1);
    for (int i = 1; i < 25; i++) cycle(1'b0, 1'b0, 10, 1'(i % 3));
    cycle(1'b0, 1'b1, 10, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 10, 1'b1);

    // start re-asserted at cycles 5 and 40, plus a mid-sweep dwell change
    cycle(1'b1, 1'b0, 10, 1'b0);
    for (int i = 1; i < 85; i++)
      cycle((i == 5) || (i == 40), 1'b0, (i < 30) ? 10 : 3, 1'(i % 2));
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);

    // dwell 4, asynchronous reset at cycle 33, then a fresh sweep
    cycle(1'b1, 1'b0, 4, 1'b1);
    for (int i = 1; i < 33; i++) cycle(1'b0, 1'b0, 4, 1'b1);
    async_reset();
    cycle(1'b1, 1'b1, 2, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 2, 1'(i % 2));
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);

    // dwell 2 long run: exercises the wrap when repeat is built in
    cycle(1'b1, 1'b0, 2, 1'b1);
    for (int i = 1; i < 40; i++) cycle(1'b0, 1'b0, 2, 1'($urandom_range(0, 1)));
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 9) == 0,
            $urandom_range(0, 59) == 0,
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
            1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
Upstream driver for the 1x8 demultiplexer. On a start pulse it sweeps select s through channels 0..NUM_CH-1 and holds each channel for a programmable dwell. It presents one data bit per channel on datain, sampled from din at each channel entry. It turns the bench-style sweep into a synthesizable, clocked sequencer with busy, done and per-channel strobe.

Parameters:
NUM_CH, 8, number of demux channels; must equal 2**SEL_W
SEL_W, 3, select width driven to the demux s input
DWELL_W, 8, width of the dwell (cycles per channel) input

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
stop  input  1  abort the active sweep
dwell  input  DWELL_W  cycles per channel; latched at start; 0 treated as 1
din  input  1  data bit; sampled at each channel entry
s  output  SEL_W  demux select
datain  output  1  demux data input
strobe  output  1  one-cycle pulse on the first cycle of each channel
busy  output  1  high while a sweep is active
done  output  1  one-cycle pulse after the last channel completes
ch_cnt  output  SEL_W+1  number of channels entered in the current or last sweep (0..NUM_CH)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: s=0, datain=0, strobe=0, busy=0, done=0, ch_cnt=0, state IDLE, dwell counter 0.
- States: IDLE, DRIVE, DONE.
- IDLE, start=1 sampled at edge E0:
  - Registered outputs at E0: s=0, datain=din, strobe=1, busy=1, ch_cnt=1.
  - dwell_q = (dwell==0) ? 1 : dwell.
  - Next state DRIVE.
- DRIVE:
  - Each channel k occupies cycles k*D .. k*D+D-1 after E0, where D = dwell_q.
  - strobe is high only on each channel's first cycle.
  - On the last cycle of channel k < NUM_CH-1: at the next edge, s=k+1, datain=din (resampled), strobe=1, ch_cnt=k+2.
  - On the last cycle of channel NUM_CH-1: next state DONE.
- DONE:
  - Lasts exactly one cycle, at cycle NUM_CH*D after E0.
  - done=1, busy=0, datain=0, strobe=0.
  - s holds NUM_CH-1 and ch_cnt holds NUM_CH.
  - Next state IDLE.
- Latency: first channel is visible on the edge that samples start (0-cycle registered latency). Total busy time = NUM_CH*D cycles.
- stop in DRIVE:
  - At the next edge: state IDLE, busy=0, datain=0, strobe=0, done stays 0.
  - s and ch_cnt hold their values, which identifies the abort point.
  - stop has priority over a channel advance on the same cycle.
- stop in IDLE or DONE: no effect. start and stop asserted together in IDLE: start wins.
- start while busy or in DONE: ignored. start must be re-asserted in IDLE to begin a new sweep.
- dwell changes mid-sweep: no effect; dwell_q is used.
- Dwell counter: DWELL_W bits, loaded with dwell_q-1 at channel entry, decrements, last cycle when it reads 0. No wrap beyond this.
- Select arithmetic: s increments modulo 2**SEL_W. Wrap from NUM_CH-1 to 0 occurs only with SEQ_REPEAT_EN.
- rst_n asserted mid-sweep: all outputs go to reset values immediately (asynchronous). No done pulse.

Optional Feature:
SEQ_REPEAT_EN
- Defined: after channel NUM_CH-1 the sequencer wraps to s=0 and continues without passing through DONE.
  - Wrap entry: datain=din, strobe=1, ch_cnt=1.
  - done pulses for one cycle concurrently with each wrap; busy stays 1.
  - The sweep ends only on stop or reset.
- Not defined: single sweep then DONE, as described above.

Test Plan:
- start with dwell=10, din=1 -> s=0..7, each held 10 cycles; strobe at cycles 0,10,...,70; datain=1 throughout; done at cycle 80 with busy=0; s=7, ch_cnt=8.
- dwell=0, din toggling 1,0,1,0 at each entry -> dwell treated as 1; s advances every cycle; datain=1,0,1,0,...; done at cycle 8.
- dwell=10, stop asserted at cycle 25 -> abort at next edge; busy=0, s=2, ch_cnt=3, datain=0; no done pulse.
- start re-asserted at cycles 5 and 40 of a dwell=10 sweep -> both ignored; single done at cycle 80; ch_cnt never exceeds 8.
- rst_n pulled low at cycle 33 of a dwell=4 sweep -> s=0, datain=0, busy=0, ch_cnt=0 without waiting for clk; a new start after release sweeps normally.
- SEQ_REPEAT_EN defined, dwell=2 -> s wraps 7->0 at cycle 16; done pulses at cycles 16 and 32; busy stays 1 until stop.
